inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the instruction memory request, fills the
// IF/ID register, absorbs one decode stall through a skid entry and discards
// in-flight responses after a branch/jump redirect.
module inst_fetch #(
  parameter int unsigned INST_WIDTH = 18,
  parameter int unsigned PC_WIDTH   = 14,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall,
  input  logic                  i_pc_src,
  input  logic [PC_WIDTH-1:0]   i_target,
  output logic                  o_imem_req,
  output logic [PC_WIDTH-1:0]   o_imem_addr,
  input  logic                  i_imem_ready,
  input  logic [INST_WIDTH-1:0] i_imem_rdata,
  output logic                  o_valid,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_inst_pc,
  output logic [3:0]            o_opcode,
  output logic [7:0]            o_funct
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] RST_ADDR = PC_WIDTH'(RESET_PC);

  state_t                state_q,     state_d;
  logic [PC_WIDTH-1:0]   addr_q,      addr_d;
  logic                  valid_q,     valid_d;
  logic [INST_WIDTH-1:0] inst_q,      inst_d;
  logic [PC_WIDTH-1:0]   inst_pc_q,   inst_pc_d;
  logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [PC_WIDTH-1:0]   skid_pc_q,   skid_pc_d;
  logic [PC_WIDTH-1:0]   pend_q,      pend_d;
  logic [PC_WIDTH-1:0]   addr_inc;

  // Next-state and IF/ID update; redirect outranks stall in every state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    pend_d      = pend_q;
    addr_inc    = addr_q + PC_WIDTH'(1);

    unique case (state_q)
      ST_FETCH: begin
        if (i_pc_src) begin
          valid_d     = 1'b0;
          skid_inst_d = '0;
          skid_pc_d   = '0;
          if (i_imem_ready) begin
            addr_d = i_target;
          end else begin
            // request still outstanding: keep it, remember where to go
            pend_d  = i_target;
            state_d = ST_DROP;
          end
        end else if (i_stall) begin
          if (i_imem_ready) begin
            skid_inst_d = i_imem_rdata;
            skid_pc_d   = addr_q;
            addr_d      = addr_inc;
            state_d     = ST_HOLD;
          end
        end else if (i_imem_ready) begin
          inst_d    = i_imem_rdata;
          inst_pc_d = addr_q;
          valid_d   = 1'b1;
          addr_d    = addr_inc;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (i_pc_src) begin
          valid_d     = 1'b0;
          skid_inst_d = '0;
          skid_pc_d   = '0;
          addr_d      = i_target;
          state_d     = ST_FETCH;
        end else if (!i_stall) begin
          inst_d      = skid_inst_q;
          inst_pc_d   = skid_pc_q;
          valid_d     = 1'b1;
          skid_inst_d = '0;
          skid_pc_d   = '0;
          state_d     = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (i_pc_src) begin
          valid_d = 1'b0;
        end
        if (i_imem_ready) begin
          // stale response discarded; newest redirect wins
          addr_d  = i_pc_src ? i_target : pend_q;
          pend_d  = '0;
          state_d = ST_FETCH;
        end else if (i_pc_src) begin
          pend_d = i_target;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_FETCH;
      addr_q      <= RST_ADDR;
      valid_q     <= 1'b0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      pend_q      <= pend_d;
    end
  end

  assign o_imem_req  = ~i_rst & (state_q != ST_HOLD);
  assign o_imem_addr = addr_q;
  assign o_valid     = valid_q;
  assign o_inst      = inst_q;
  assign o_inst_pc   = inst_pc_q;
  assign o_opcode    = inst_q[INST_WIDTH-1 -: 4];
  assign o_funct     = inst_q[7:0];

endmodule
